// File: rtl/fill_rect_word_gen_pkg.sv
// Shared encodings for the fill-rectangle word generator: FSM states, command
// modes, arbiter op code and a small modulo-3 helper for channel phase tracking.
package fill_rect_word_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;
  localparam logic OP_WRITE     = 1'b1;

  // Reduces a small sum (at most 6) modulo 3.
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    if (v >= 3'd6) begin
      return 2'd0;
    end else if (v >= 3'd3) begin
      return 2'(v - 3'd3);
    end else begin
      return v[1:0];
    end
  endfunction

endpackage

// File: rtl/fill_rect_word_gen_pack.sv
// Packs the bytes of one span that fall into a single aligned word: lanes start
// at the byte offset, stop at the remaining count and cycle R/G/B from phase.
module fill_rect_word_pack
  import fill_rect_word_gen_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  remaining,
  input  logic [1:0]  phase,
  input  logic [7:0]  r_byte,
  input  logic [7:0]  g_byte,
  input  logic [7:0]  b_byte,
  output logic [3:0]  wben,
  output logic [31:0] data,
  output logic [2:0]  used
);

  logic [2:0] k;

  always_comb begin
    wben = '0;
    data = '0;
    used = '0;
    k    = '0;
    for (int j = 0; j < 4; j++) begin
      k = 3'(j) - {1'b0, offset};
      if ((2'(j) >= offset) && (k < remaining)) begin
        wben[j] = 1'b1;
        case (wrap3(3'(phase) + k))
          2'd0:    data[8*j +: 8] = r_byte;
          2'd1:    data[8*j +: 8] = g_byte;
          default: data[8*j +: 8] = b_byte;
        endcase
        used = used + 3'd1;
      end
    end
  end

endmodule

// File: rtl/fill_rect_word_gen.sv
// Turns one latched rectangle command into a stream of word-aligned, byte-enabled
// framebuffer writes (solid or outline) offered to the arbiter over rts/rtr.
module fill_rect_word_gen
  import fill_rect_word_gen_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 16,
  parameter int CH_W   = 4,
  parameter int STRIDE = 240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cmd_mode,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DIM_W-1:0]  cmd_wid,
  input  logic [DIM_W-1:0]  cmd_hgt,
  input  logic [CH_W-1:0]   cmd_rval,
  input  logic [CH_W-1:0]   cmd_gval,
  input  logic [CH_W-1:0]   cmd_bval,
  output logic              busy,
  output logic              done,
  output logic              arb_out_rts,
  input  logic              arb_in_rtr,
  output logic [ADDR_W-1:0] arb_out_addr,
  output logic [3:0]        arb_out_wben,
  output logic [31:0]       arb_out_data,
  output logic              arb_out_op
);

  localparam int CNT_W = DIM_W + 2;

  state_t state, state_nxt;

  logic              mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [DIM_W-1:0]  wid_q, hgt_q;
  logic [CH_W-1:0]   r_q, g_q, b_q;

  // Position of the current word: row, row base address, byte index within
  // the row, end of the current span, channel phase and which outline span.
  logic [DIM_W-1:0]  row_q;
  logic [ADDR_W-1:0] row_addr_q;
  logic [CNT_W-1:0]  pos_q, end_q;
  logic [1:0]        phase_q;
  logic              span_q;

  logic [CNT_W-1:0]  wid3, remaining, next_pos;
  logic [ADDR_W-1:0] byte_addr;
  logic [2:0]        rem_clip, used;
  logic [3:0]        pk_wben;
  logic [31:0]       pk_data;
  logic              last_row, outline_ok, interior, next_interior;
  logic              span_last, xfc;

  assign wid3          = ({2'b00, wid_q} << 1) + {2'b00, wid_q};
  assign last_row      = (row_q == hgt_q - 1'b1);
  assign outline_ok    = (mode_q == MODE_OUTLINE) && (wid_q > DIM_W'(2));
  assign interior      = outline_ok && (row_q != '0) && !last_row;
  assign next_interior = outline_ok && ((row_q + 1'b1) != (hgt_q - 1'b1));
  assign byte_addr     = row_addr_q + ADDR_W'(pos_q);
  assign remaining     = end_q - pos_q;
  assign rem_clip      = (remaining > CNT_W'(3)) ? 3'd4 : remaining[2:0];
  assign next_pos      = pos_q + CNT_W'(used);
  assign span_last     = (next_pos >= end_q);
  assign xfc           = arb_out_rts & arb_in_rtr;

  fill_rect_word_pack u_pack (
    .offset    (byte_addr[1:0]),
    .remaining (rem_clip),
    .phase     (phase_q),
    .r_byte    (8'(r_q)),
    .g_byte    (8'(g_q)),
    .b_byte    (8'(b_q)),
    .wben      (pk_wben),
    .data      (pk_data),
    .used      (used)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    done         = 1'b0;
    arb_out_rts  = 1'b0;
    arb_out_addr = '0;
    arb_out_wben = '0;
    arb_out_data = '0;
    arb_out_op   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        busy      = 1'b1;
        state_nxt = ((wid_q == '0) || (hgt_q == '0)) ? ST_DONE : ST_EMIT;
      end
      ST_EMIT: begin
        busy         = 1'b1;
        arb_out_rts  = 1'b1;
        arb_out_addr = {byte_addr[ADDR_W-1:2], 2'b00};
        arb_out_wben = pk_wben;
        arb_out_data = pk_data;
        arb_out_op   = OP_WRITE;
        if (xfc && span_last && !(interior && !span_q) && last_row) begin
          state_nxt = ST_DONE;
        end
      end
      default: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_FILL;
      base_q     <= '0;
      wid_q      <= '0;
      hgt_q      <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      row_q      <= '0;
      row_addr_q <= '0;
      pos_q      <= '0;
      end_q      <= '0;
      phase_q    <= '0;
      span_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q <= cmd_mode;
            base_q <= cmd_addr;
            wid_q  <= cmd_wid;
            hgt_q  <= cmd_hgt;
            r_q    <= cmd_rval;
            g_q    <= cmd_gval;
            b_q    <= cmd_bval;
          end
        end
        ST_LOAD: begin
          // Row 0 is always a full span, whatever the mode.
          row_q      <= '0;
          row_addr_q <= base_q;
          pos_q      <= '0;
          end_q      <= wid3;
          phase_q    <= 2'd0;
          span_q     <= 1'b0;
        end
        ST_EMIT: begin
          if (xfc) begin
            if (!span_last) begin
              pos_q   <= next_pos;
              phase_q <= wrap3(3'(phase_q) + used);
            end else if (interior && !span_q) begin
              // Jump to the right-hand pixel; 3*wid-3 is a multiple of 3.
              span_q  <= 1'b1;
              pos_q   <= wid3 - CNT_W'(3);
              end_q   <= wid3;
              phase_q <= 2'd0;
            end else if (!last_row) begin
              row_q      <= row_q + 1'b1;
              row_addr_q <= row_addr_q + ADDR_W'(STRIDE);
              pos_q      <= '0;
              end_q      <= next_interior ? CNT_W'(3) : wid3;
              phase_q    <= 2'd0;
              span_q     <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fill_rect_word_gen.sv
// Scoreboard bench for fill_rect_word_gen: a byte-level rectangle model fills
// an expected-word queue; a negedge monitor pops and compares on every transfer.
module tb_fill_rect_word_gen;

  localparam int ADDR_W = 16;
  localparam int DIM_W  = 16;
  localparam int CH_W   = 4;
  localparam int STRIDE = 240;

  logic              clk, rst, start, cmd_mode;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DIM_W-1:0]  cmd_wid, cmd_hgt;
  logic [CH_W-1:0]   cmd_rval, cmd_gval, cmd_bval;
  logic              busy, done, arb_out_rts, arb_in_rtr, arb_out_op;
  logic [ADDR_W-1:0] arb_out_addr;
  logic [3:0]        arb_out_wben;
  logic [31:0]       arb_out_data;

  fill_rect_word_gen #(
    .ADDR_W(ADDR_W), .DIM_W(DIM_W), .CH_W(CH_W), .STRIDE(STRIDE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_mode(cmd_mode),
    .cmd_addr(cmd_addr), .cmd_wid(cmd_wid), .cmd_hgt(cmd_hgt),
    .cmd_rval(cmd_rval), .cmd_gval(cmd_gval), .cmd_bval(cmd_bval),
    .busy(busy), .done(done), .arb_out_rts(arb_out_rts), .arb_in_rtr(arb_in_rtr),
    .arb_out_addr(arb_out_addr), .arb_out_wben(arb_out_wben),
    .arb_out_data(arb_out_data), .arb_out_op(arb_out_op)
  );

  int checks = 0;
  int errors = 0;
  logic [51:0] exp_q[$];
  int rtr_mode = 0;          // 0: always ready, 1: random, 2: held low
  logic [51:0] cur_word;
  logic [51:0] prev_word;
  bit stall_prev = 0;

  assign cur_word = {arb_out_addr, arb_out_wben, arb_out_data};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (rtr_mode)
      0:       arb_in_rtr = 1'b1;
      1:       arb_in_rtr = ($urandom_range(0, 2) != 0);
      default: arb_in_rtr = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] chan(input int k, input logic [CH_W-1:0] r,
                                      input logic [CH_W-1:0] g, input logic [CH_W-1:0] b);
    case (k % 3)
      0:       return 8'(r);
      1:       return 8'(g);
      default: return 8'(b);
    endcase
  endfunction

  task automatic push_span(input int base, input int s, input int e,
                           input logic [CH_W-1:0] r, input logic [CH_W-1:0] g,
                           input logic [CH_W-1:0] b);
    int cur_wa = -1;
    int a, wa, lane;
    logic [3:0]  wb = 4'h0;
    logic [31:0] dt = 32'h0;
    for (int k = s; k < e; k++) begin
      a  = (base + k) & 32'hFFFF;
      wa = a & 32'hFFFC;
      if (wa != cur_wa) begin
        if (cur_wa >= 0) exp_q.push_back({16'(cur_wa), wb, dt});
        cur_wa = wa;
        wb = 4'h0;
        dt = 32'h0;
      end
      lane = a & 3;
      wb[lane] = 1'b1;
      dt[8*lane +: 8] = chan(k, r, g, b);
    end
    if (cur_wa >= 0) exp_q.push_back({16'(cur_wa), wb, dt});
  endtask

  task automatic push_model(input logic mode, input logic [15:0] addr, input int wid,
                            input int hgt, input logic [CH_W-1:0] r,
                            input logic [CH_W-1:0] g, input logic [CH_W-1:0] b);
    int base;
    for (int row = 0; row < hgt; row++) begin
      base = (int'(addr) + row * STRIDE) & 32'hFFFF;
      if (mode == 1'b0 || row == 0 || row == hgt - 1 || wid <= 2) begin
        push_span(base, 0, 3 * wid, r, g, b);
      end else begin
        push_span(base, 0, 3, r, g, b);
        push_span(base, 3 * wid - 3, 3 * wid, r, g, b);
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("stall_rts", 64'(arb_out_rts), 64'd1);
        check("stall_word", 64'(cur_word), 64'(prev_word));
      end
      if (arb_out_rts && arb_in_rtr) begin
        check("op_write", 64'(arb_out_op), 64'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word actual=%0h required=none", cur_word);
        end else begin
          check("word", 64'(cur_word), 64'(exp_q.pop_front()));
        end
      end
      stall_prev = arb_out_rts && !arb_in_rtr;
      prev_word  = cur_word;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_start(input logic mode, input logic [15:0] addr, input int wid,
                             input int hgt, input logic [CH_W-1:0] r,
                             input logic [CH_W-1:0] g, input logic [CH_W-1:0] b);
    @(posedge clk); #1;
    cmd_mode = mode; cmd_addr = addr; cmd_wid = 16'(wid); cmd_hgt = 16'(hgt);
    cmd_rval = r; cmd_gval = g; cmd_bval = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_cmd(input logic mode, input logic [15:0] addr, input int wid,
                         input int hgt, input logic [CH_W-1:0] r,
                         input logic [CH_W-1:0] g, input logic [CH_W-1:0] b,
                         input int rmode, input bit hold, input bit poke);
    int n, cyc;
    push_model(mode, addr, wid, hgt, r, g, b);
    n = exp_q.size();
    rtr_mode = hold ? 2 : rmode;
    issue_start(mode, addr, wid, hgt, r, g, b);
    check("busy_load", 64'(busy), 64'd1);
    check("done_load", 64'(done), 64'd0);
    @(posedge clk); #1;
    cyc = 2;
    if (n == 0) begin
      check("zero_done", 64'(done), 64'd1);
      check("zero_rts", 64'(arb_out_rts), 64'd0);
      check("zero_busy", 64'(busy), 64'd0);
    end else begin
      check("rts_first", 64'(arb_out_rts), 64'd1);
      while (!done && cyc < 4000) begin
        if (hold && cyc == 7) rtr_mode = rmode;
        if (poke && cyc == 4) begin
          start = 1'b1; cmd_wid = 16'd7; cmd_addr = 16'h1234; cmd_mode = ~mode;
        end
        @(posedge clk); #1;
        cyc++;
        start = 1'b0;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL done_timeout actual=%0d cycles required=done", cyc);
      end
      check("rts_at_done", 64'(arb_out_rts), 64'd0);
      check("busy_at_done", 64'(busy), 64'd0);
      if (rmode == 0 && !hold && !poke) check("throughput", 64'(cyc), 64'(n + 2));
    end
    check("leftover", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    if (poke) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    if (poke) begin
      @(posedge clk); #1;
      check("start_at_done_ignored", 64'(busy), 64'd0);
    end
  endtask

  task automatic reset_mid_emit();
    int cyc = 0;
    push_model(1'b0, 16'h0100, 20, 4, 4'h5, 4'h6, 4'h7);
    rtr_mode = 1;
    issue_start(1'b0, 16'h0100, 20, 4, 4'h5, 4'h6, 4'h7);
    while (!arb_out_rts && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rts_before_reset", 64'(arb_out_rts), 64'd1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_rts", 64'(arb_out_rts), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_word", 64'(cur_word), 64'd0);
    check("rst_op", 64'(arb_out_op), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0; start = 1'b0; cmd_mode = 1'b0; cmd_addr = '0;
    cmd_wid = '0; cmd_hgt = '0; cmd_rval = '0; cmd_gval = '0; cmd_bval = '0;
    arb_in_rtr = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset_rts", 64'(arb_out_rts), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_word", 64'(cur_word), 64'd0);
    check("reset_op", 64'(arb_out_op), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases from the test plan.
    run_cmd(1'b0, 16'h0002, 2, 1, 4'h1, 4'h2, 4'h3, 0, 0, 0);
    run_cmd(1'b0, 16'h0000, 4, 2, 4'h1, 4'h2, 4'h3, 0, 0, 0);
    run_cmd(1'b1, 16'h0000, 4, 3, 4'h1, 4'h2, 4'h3, 0, 0, 0);
    run_cmd(1'b1, 16'h0013, 9, 5, 4'hA, 4'hB, 4'hC, 1, 1, 0);
    run_cmd(1'b0, 16'h0040, 0, 3, 4'h1, 4'h1, 4'h1, 0, 0, 0);
    run_cmd(1'b0, 16'h0040, 3, 0, 4'h1, 4'h1, 4'h1, 0, 0, 0);
    run_cmd(1'b0, 16'h0021, 12, 3, 4'h3, 4'h9, 4'hF, 0, 1, 1);
    run_cmd(1'b1, 16'h0005, 2, 4, 4'h7, 4'h8, 4'h9, 1, 0, 0);
    run_cmd(1'b0, 16'hFFF6, 5, 2, 4'hE, 4'hD, 4'hC, 1, 0, 0);
    run_cmd(1'b1, 16'h0001, 3, 2, 4'h2, 4'h4, 4'h6, 0, 0, 0);

    // Randomized commands and ready patterns.
    for (int i = 0; i < 30; i++) begin
      run_cmd(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
              $urandom_range(0, 20), $urandom_range(0, 5),
              4'($urandom), 4'($urandom), 4'($urandom),
              $urandom_range(0, 1), 1'($urandom_range(0, 3) == 0), 0);
    end

    reset_mid_emit();
    run_cmd(1'b1, 16'h0202, 6, 4, 4'h1, 4'h5, 4'h9, 1, 0, 0);
    run_cmd(1'b0, 16'h0003, 7, 2, 4'h8, 4'h4, 4'h2, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
